mult_requester: RTL and testbench

- Initiator side of the multiplier handshake (valid_data / Done_Flag / ack / ret_ack).
- Queues operand pairs from an upstream producer in a small FIFO and issues them one at a time to the multiplier.
- Captures each product and presents it downstream on a valid/ready interface.
- Sits between the datapath controller and the multiplier; it replaces bench-level handshake driving in the system build.

---
 rtl/mult_requester.sv | 151 +++++++++++++++
 tb/tb_mult_requester.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_requester.sv
// Initiator side of the multiplier handshake: buffers operand pairs in a small FIFO,
// issues them one at a time and hands each captured product downstream on valid/ready.
module mult_requester #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 valid_data,
    input  logic                 Done_Flag,
    input  logic [2*WIDTH-1:0]   producto,
    output logic                 ack,
    input  logic                 ret_ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_producto,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, ACK, OUT} state_t;

    state_t          state;
    logic [PW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [TW-1:0]   tmo_cnt;
    logic            push;
    logic            pop;
    logic            tmo_hit;
    logic            ack_done;
    logic            out_done;
    logic            to_idle;
    logic            busy_nx;

    // Handshake decode shared by the FIFO, the FSM and the registered busy flag
    always_comb begin
        push     = in_valid && in_ready;
        pop      = (state == IDLE) && (count != '0);
        tmo_hit  = (tmo_cnt + TW'(1)) == TW'(TIMEOUT);
        ack_done = (state == ACK) && ret_ack && !Done_Flag;
        out_done = (state == OUT) && res_ready;
        to_idle  = out_done
                 || ((state == REQ) && !Done_Flag && tmo_hit)
                 || ((state == ACK) && !ack_done && tmo_hit);
        count_nx = count + CW'(push) - CW'(pop);
        busy_nx  = (count_nx != '0) || pop || ((state != IDLE) && !to_idle);
    end

    // Operand storage carries no reset; only pointers and count define its contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nx;
            in_ready <= count_nx != CW'(DEPTH);
            busy     <= busy_nx;
        end
    end

    // Request / acknowledge / output sequencing with a per-phase abort counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mul_a        <= '0;
            mul_b        <= '0;
            valid_data   <= 1'b0;
            ack          <= 1'b0;
            res_valid    <= 1'b0;
            res_producto <= '0;
            timeout_err  <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {mul_a, mul_b} <= mem[rd_ptr];
                        valid_data     <= 1'b1;
                        tmo_cnt        <= '0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (Done_Flag) begin
                        res_producto <= producto;
                        valid_data   <= 1'b0;
                        ack          <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= ACK;
                    end else if (tmo_hit) begin
                        valid_data  <= 1'b0;
                        timeout_err <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ACK: begin
                    if (ack_done) begin
                        ack       <= 1'b0;
                        res_valid <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= OUT;
                    end else if (tmo_hit) begin
                        ack         <= 1'b0;
                        timeout_err <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_requester.sv
// Randomised and directed bench for mult_requester: a transaction-level reference model
// (operand queue plus phase/deadline bookkeeping) is compared against the DUT every cycle.
module tb_mult_requester;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_a = '0;
    logic [31:0]        in_b = '0;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic               valid_data;
    logic               Done_Flag = 1'b0;
    logic [63:0]        producto = '0;
    logic               ack;
    logic               ret_ack = 1'b0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [63:0]        res_producto;
    logic               busy;
    logic               timeout_err;

    mult_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .valid_data(valid_data),
        .Done_Flag(Done_Flag), .producto(producto), .ack(ack), .ret_ack(ret_ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_producto(res_producto),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: operand queue, current phase and the cycle the phase began
    localparam int M_IDLE = 0, M_REQ = 1, M_ACK = 2, M_OUT = 3;
    logic [63:0] m_q[$];
    logic [63:0] m_log[$];
    int          m_ph = M_IDLE;
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_res = '0;
    logic        m_tmo = 1'b0;
    longint      m_cyc = 0, m_start = 0;
    logic        m_pushed = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ph = M_IDLE; m_a = '0; m_b = '0; m_res = '0;
            m_tmo = 1'b0; m_cyc = 0; m_start = 0; m_pushed = 1'b0;
        end else begin
            bit acc;
            acc = in_valid && (m_q.size() < DEPTH);
            m_cyc++;
            case (m_ph)
                M_IDLE: if (m_q.size() != 0) begin
                    {m_a, m_b} = m_q.pop_front();
                    m_ph = M_REQ; m_start = m_cyc;
                end
                M_REQ: if (Done_Flag) begin
                    m_res = producto; m_ph = M_ACK; m_start = m_cyc;
                end else if (m_cyc - m_start == longint'(TIMEOUT)) begin
                    m_ph = M_IDLE; m_tmo = 1'b1;
                end
                M_ACK: if (ret_ack && !Done_Flag) begin
                    m_ph = M_OUT;
                end else if (m_cyc - m_start == longint'(TIMEOUT)) begin
                    m_ph = M_IDLE; m_tmo = 1'b1;
                end
                default: if (res_ready) begin
                    m_log.push_back(m_res); m_ph = M_IDLE;
                end
            endcase
            if (acc) m_q.push_back({in_a, in_b});
            m_pushed = acc;
        end
    end

    // Multiplier / downstream stand-in knobs
    bit chk_en = 0, stall = 0, spur = 0, fast_ret = 1;
    int rr_mode = 2, fix_lat = 0, lmax = 6;
    int r_ph = 0, r_lat = 0;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("in_ready",     64'(in_ready),     64'(m_q.size() < DEPTH));
            chk("busy",         64'(busy),         64'((m_ph != M_IDLE) || (m_q.size() != 0)));
            chk("valid_data",   64'(valid_data),   64'(m_ph == M_REQ));
            chk("ack",          64'(ack),          64'(m_ph == M_ACK));
            chk("res_valid",    64'(res_valid),    64'(m_ph == M_OUT));
            chk("mul_a",        64'(mul_a),        64'(m_a));
            chk("mul_b",        64'(mul_b),        64'(m_b));
            chk("res_producto", res_producto,      m_res);
            chk("timeout_err",  64'(timeout_err),  64'(m_tmo));
            chk("vd_ack_excl",  64'(valid_data & ack), 64'(0));
        end
        if (reset) begin
            Done_Flag = 1'b0; ret_ack = 1'b0; producto = '0; r_ph = 0;
        end else begin
            case (r_ph)
                0: begin
                    ret_ack = 1'b0;
                    if (valid_data) begin
                        Done_Flag = 1'b0;
                        r_lat = stall ? 1000000 : (fix_lat != 0 ? fix_lat : int'($urandom_range(1, lmax)));
                        r_ph = 1;
                    end else begin
                        Done_Flag = spur && ($urandom_range(0, 3) == 0);
                        producto  = {$urandom, $urandom};
                    end
                end
                1: begin
                    if (!valid_data) begin
                        r_ph = 0; Done_Flag = 1'b0;
                    end else begin
                        r_lat--;
                        if (r_lat == 0) begin
                            Done_Flag = 1'b1;
                            producto  = {32'b0, mul_a} * {32'b0, mul_b};
                            r_ph = 2;
                        end
                    end
                end
                2: begin
                    if (!valid_data && !ack) begin
                        r_ph = 0; Done_Flag = 1'b0; ret_ack = 1'b0;
                    end else if (ack) begin
                        if (fast_ret) begin
                            Done_Flag = 1'b0; ret_ack = 1'b1; r_ph = 3;
                        end else begin
                            case ($urandom_range(0, 3))
                                0: ;
                                1: ret_ack = 1'b1;
                                default: begin Done_Flag = 1'b0; ret_ack = 1'b1; r_ph = 3; end
                            endcase
                        end
                    end
                end
                default: if (!ack) begin
                    ret_ack = 1'b0; r_ph = 0;
                end
            endcase
        end
        res_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 2);
    end

    // Offer one pair and hold it until the model says it was accepted
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        do begin
            @(negedge clk);
            k++;
        end while (!m_pushed && k < 1000);
        chk("push_bound", 64'(k < 1000), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(m_ph == M_IDLE && m_q.size() == 0 && r_ph == 0) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_bound", 64'(k < 6000), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit: simulation did not finish, got stuck at t=%0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        logic [63:0] exp6 [6];
        int base, hi, k, lsz;
        exp6 = '{64'd2, 64'd12, 64'd30, 64'd56, 64'd90, 64'd132};

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(valid_data), 64'(0));
        chk("rst_prod", res_producto, 64'(0));
        @(negedge clk);
        reset = 1'b0; chk_en = 1;
        @(negedge clk);

        // Single 10x10 with an 8-cycle multiplier
        fix_lat = 8;
        push(32'd10, 32'd10);
        chk("t1_not_yet", 64'(valid_data), 64'(0));
        @(negedge clk);
        chk("t1_issue", 64'(valid_data), 64'(1));
        wait_idle();
        chk("t1_prod", m_log[m_log.size()-1], 64'd100);
        chk("t1_busy", 64'(busy), 64'(0));

        // Back-to-back edge operands
        fix_lat = 3;
        base = m_log.size();
        push(32'd19347, 32'd0);
        push(32'd0, 32'd0);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        chk("t2_cnt", 64'(m_log.size() - base), 64'(3));
        chk("t2_r0", m_log[base],     64'd0);
        chk("t2_r1", m_log[base + 1], 64'd0);
        chk("t2_r2", m_log[base + 2], 64'hFFFF_FFFE_0000_0001);

        // Slow multiplier fills the FIFO; sixth push waits for the first completion
        fix_lat = 12;
        base = m_log.size();
        for (int i = 0; i < 5; i++) push(32'(2 * i + 1), 32'(2 * i + 2));
        chk("t3_full_ready", 64'(in_ready), 64'(0));
        chk("t3_full_depth", 64'(m_q.size()), 64'(4));
        push(32'd11, 32'd12);
        wait_idle();
        for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), m_log[base + i], exp6[i]);

        // Downstream stall holds the result and blocks the next issue
        fix_lat = 2; rr_mode = 1;
        push(32'd6, 32'd7);
        push(32'd8, 32'd9);
        k = 0;
        while (m_ph != M_OUT && k < 200) begin @(negedge clk); k++; end
        chk("t4_reach_out", 64'(k < 200), 64'(1));
        repeat (20) @(negedge clk);
        chk("t4_no_issue", 64'(valid_data), 64'(0));
        chk("t4_hold_valid", 64'(res_valid), 64'(1));
        chk("t4_hold_prod", res_producto, 64'd42);
        rr_mode = 2;
        wait_idle();
        chk("t4_second", m_log[m_log.size()-1], 64'd72);

        // Multiplier never answers: abort after TIMEOUT cycles, next op proceeds
        stall = 1;
        push(32'h11, 32'h22);
        push(32'd3, 32'd5);
        hi = valid_data ? 1 : 0;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (timeout_err) break;
            if (valid_data) hi++;
        end
        stall = 0;
        chk("t5_req_len", 64'(hi), 64'(15));
        chk("t5_flag", 64'(timeout_err), 64'(1));
        wait_idle();
        chk("t5_next_ok", m_log[m_log.size()-1], 64'd15);
        chk("t5_sticky", 64'(timeout_err), 64'(1));

        // Asynchronous reset mid-request with two entries queued
        stall = 1;
        push(32'd7, 32'd9);
        push(32'd2, 32'd2);
        push(32'd4, 32'd4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 64'(valid_data), 64'(0));
        chk("t6_ack", 64'(ack), 64'(0));
        chk("t6_res_valid", 64'(res_valid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_tmo", 64'(timeout_err), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(1));
        chk("t6_mul_a", 64'(mul_a), 64'(0));
        chk("t6_prod", res_producto, 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; stall = 0;
        lsz = m_log.size();
        repeat (30) @(negedge clk);
        chk("t6_no_result", 64'(m_log.size()), 64'(lsz));
        chk("t6_idle", 64'(busy), 64'(0));

        // Randomised traffic: random latency (some aborts), spurious flags, random ret_ack/res_ready
        fix_lat = 0; lmax = 18; spur = 1; fast_ret = 0; rr_mode = 0;
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a, b;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            push(a, b);
        end
        wait_idle();
        rr_mode = 2; spur = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
